// File: rtl/ram_dp_clr.sv
// Simple dual-port RAM (one write, one read port, single clock) with byte enables,
// 1/2-cycle read latency, defined collision behaviour and a post-reset clear sweep.
// Optional per-byte even parity and ParErr output: define RAM_DP_CLR_PARITY_EN.
module ram_dp_clr #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int RD_LAT       = 1,
    parameter int RD_FIRST     = 0,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic [DATA_W/8-1:0] WrBe,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [DATA_W-1:0] RdData,
    output logic              RdValid,
    output logic              Busy
`ifdef RAM_DP_CLR_PARITY_EN
    ,
    output logic              ParErr
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              clr_we;
    logic              wr_acc;
    logic              rd_acc;
    logic              hit;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_old;
    logic [DATA_W-1:0] rd_merged;
    logic [DATA_W-1:0] rd_word;

    // State register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= (CLEAR_ON_RST != 0) ? CLEAR : IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (cnt == '1) state_nxt = IDLE;
            default: state_nxt = state;
        endcase
    end

    // Output logic
    always_comb begin
        Busy   = (state == CLEAR);
        clr_we = (state == CLEAR) && !Rst;
    end

    assign wr_acc = WrEn && (state == IDLE) && !Rst;
    assign rd_acc = RdEn && (state == IDLE) && !Rst;

    // Read word: old contents, or the byte-merged write word on a write-first collision
    always_comb begin
        rd_old    = mem[RdAddr];
        rd_merged = rd_old;
        for (int unsigned i = 0; i < NB; i++) begin
            if (WrBe[i]) rd_merged[8*i +: 8] = WrData[8*i +: 8];
        end
        hit     = WrEn && (WrAddr == RdAddr);
        rd_word = ((RD_FIRST == 0) && hit) ? rd_merged : rd_old;
    end

`ifdef RAM_DP_CLR_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_par_old;
    logic [NB-1:0] rd_par_merged;
    logic [NB-1:0] rd_par;
    logic          rd_perr;

    always_comb begin
        rd_par_old    = par_mem[RdAddr];
        rd_par_merged = rd_par_old;
        wr_par        = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            wr_par[i] = ^WrData[8*i +: 8];
            if (WrBe[i]) rd_par_merged[i] = wr_par[i];
        end
        rd_par  = ((RD_FIRST == 0) && hit) ? rd_par_merged : rd_par_old;
        rd_perr = 1'b0;
        for (int unsigned i = 0; i < NB; i++) begin
            if ((^rd_word[8*i +: 8]) != rd_par[i]) rd_perr = 1'b1;
        end
    end
`endif

    // Storage: the clear sweep has priority, user writes only when idle
    always_ff @(posedge Clk) begin
        if (clr_we) begin
            mem[cnt] <= '0;
`ifdef RAM_DP_CLR_PARITY_EN
            par_mem[cnt] <= '0;
`endif
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (WrBe[i]) begin
                    mem[WrAddr][8*i +: 8] <= WrData[8*i +: 8];
`ifdef RAM_DP_CLR_PARITY_EN
                    par_mem[WrAddr][i] <= wr_par[i];
`endif
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              s1_valid;
            logic [DATA_W-1:0] s1_data;
`ifdef RAM_DP_CLR_PARITY_EN
            logic              s1_perr;
`endif
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    s1_valid <= 1'b0;
                    s1_data  <= '0;
                    RdValid  <= 1'b0;
                    RdData   <= '0;
`ifdef RAM_DP_CLR_PARITY_EN
                    s1_perr  <= 1'b0;
                    ParErr   <= 1'b0;
`endif
                end else begin
                    s1_valid <= rd_acc;
                    if (rd_acc) s1_data <= rd_word;
                    RdValid <= s1_valid;
                    if (s1_valid) RdData <= s1_data;
`ifdef RAM_DP_CLR_PARITY_EN
                    s1_perr <= rd_acc && rd_perr;
                    ParErr  <= s1_valid && s1_perr;
`endif
                end
            end
        end else begin : g_lat1
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    RdValid <= 1'b0;
                    RdData  <= '0;
`ifdef RAM_DP_CLR_PARITY_EN
                    ParErr  <= 1'b0;
`endif
                end else begin
                    RdValid <= rd_acc;
                    if (rd_acc) RdData <= rd_word;
`ifdef RAM_DP_CLR_PARITY_EN
                    ParErr <= rd_acc && rd_perr;
`endif
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ram_dp_clr.sv
// Scoreboard bench for ram_dp_clr: two instances (RD_LAT=1/write-first and
// RD_LAT=2/read-first) driven by the same directed vectors.
module tb_ram_dp_clr;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        WrEn;
    logic [3:0]  WrAddr;
    logic [31:0] WrData;
    logic [3:0]  WrBe;
    logic        RdEn;
    logic [3:0]  RdAddr;

    logic [31:0] RdData_a, RdData_b;
    logic        RdValid_a, RdValid_b;
    logic        Busy_a, Busy_b;
    logic        perr_a, perr_b;

    always #5 Clk = ~Clk;

    ram_dp_clr #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1), .RD_FIRST(0), .CLEAR_ON_RST(1)) u_a (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrBe(WrBe),
        .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData_a), .RdValid(RdValid_a), .Busy(Busy_a)
`ifdef RAM_DP_CLR_PARITY_EN
        , .ParErr(perr_a)
`endif
    );

    ram_dp_clr #(.DATA_W(32), .ADDR_W(4), .RD_LAT(2), .RD_FIRST(1), .CLEAR_ON_RST(1)) u_b (
        .Clk(Clk), .Rst(Rst), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrBe(WrBe),
        .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData_b), .RdValid(RdValid_b), .Busy(Busy_b)
`ifdef RAM_DP_CLR_PARITY_EN
        , .ParErr(perr_b)
`endif
    );

`ifndef RAM_DP_CLR_PARITY_EN
    assign perr_a = 1'b0;
    assign perr_b = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        perr;
    } rexp_t;

    typedef struct {
        int   cyc;
        logic busy;
        logic rd0;
    } sexp_t;

    rexp_t q [2][$];
    sexp_t qs[$];
    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    bit    done = 1'b0;
    bit    fin = 1'b0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs;
        WrEn = 1'b0; WrAddr = '0; WrData = '0; WrBe = '0;
        RdEn = 1'b0; RdAddr = '0;
    endtask

    // One cycle of stimulus; a read pushes each instance's expected word and arrival cycle.
    task automatic op(input bit we, input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be,
                      input bit re, input logic [3:0] ra, input logic [31:0] ea, input logic [31:0] eb,
                      input logic pe);
        WrEn = we; WrAddr = wa; WrData = wd; WrBe = be;
        RdEn = re; RdAddr = ra;
        if (re) begin
            q[0].push_back('{cyc + 1, ea, pe});
            q[1].push_back('{cyc + 2, eb, pe});
        end
        tick();
        idle_inputs();
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        op(1'b1, a, d, be, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, e, e, 1'b0);
    endtask

    // Pulse Rst, then watch n cycles of Busy; optionally poke a write+read on the last sweep cycle.
    task automatic reset_watch(input int n, input bit poke);
        int r;
        Rst = 1'b1;
        tick();
        r = cyc;
        for (int i = 0; i < n && i <= 16; i++) begin
            qs.push_back('{r + i, (i < 16), (i == 0)});
        end
        Rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (poke && i == 15) begin
                WrEn = 1'b1; WrAddr = 4'd2; WrData = 32'hDEADBEEF; WrBe = 4'hF;
                RdEn = 1'b1; RdAddr = 4'd2;
            end
            tick();
            idle_inputs();
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [31:0] d, input logic pe);
        rexp_t e;
        string nm;
        nm = (k == 0) ? "a" : "b";
        if (v === 1'b1) begin
            if (q[k].size() == 0) begin
                check({"unexpected_rdvalid_", nm}, 32'(v), 32'd0);
            end else begin
                e = q[k].pop_front();
                check({"rddata_", nm}, d, e.data);
                check({"rdvalid_cycle_", nm}, 32'(cyc), 32'(e.cyc));
`ifdef RAM_DP_CLR_PARITY_EN
                check({"parerr_", nm}, 32'(pe), 32'(e.perr));
`endif
            end
        end else if (q[k].size() > 0 && q[k][0].cyc < cyc) begin
            e = q[k].pop_front();
            check({"missing_rdvalid_", nm}, 32'(v), 32'd1);
        end
    endtask

    // Monitor: pops and compares independently of the stimulus process
    always @(negedge Clk) begin
        sexp_t s;
        if (!fin) begin
            if (qs.size() > 0 && qs[0].cyc == cyc) begin
                s = qs.pop_front();
                check("busy_a", 32'(Busy_a), 32'(s.busy));
                check("busy_b", 32'(Busy_b), 32'(s.busy));
                if (s.rd0) begin
                    check("reset_rddata_a", RdData_a, 32'd0);
                    check("reset_rddata_b", RdData_b, 32'd0);
                    check("reset_rdvalid_a", 32'(RdValid_a), 32'd0);
                    check("reset_rdvalid_b", 32'(RdValid_b), 32'd0);
                end
            end
            mon(0, RdValid_a, RdData_a, perr_a);
            mon(1, RdValid_b, RdData_b, perr_b);
            if (done) begin
                check("pending_reads_a", 32'(q[0].size()), 32'd0);
                check("pending_reads_b", 32'(q[1].size()), 32'd0);
                check("pending_state", 32'(qs.size()), 32'd0);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                fin = 1'b1;
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        Rst = 1'b0;
        idle_inputs();
        tick();
        tick();

        // Power-up clear, then fill with 0xAA pattern and clear again
        reset_watch(17, 1'b0);
        for (int a = 0; a < 16; a++) wr(4'(a), 32'hAAAAAAAA, 4'hF);
        rd(4'd5, 32'hAAAAAAAA);
        tick();
        tick();
        reset_watch(17, 1'b0);
        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0);
        tick();
        tick();

        // Reset mid-sweep restarts it; a write/read issued while busy is dropped
        wr(4'd2, 32'h77777777, 4'hF);
        reset_watch(7, 1'b0);
        reset_watch(17, 1'b1);
        rd(4'd2, 32'h0);
        rd(4'd15, 32'h0);

        // Byte enables, including the all-zero no-op
        wr(4'd1, 32'h11223344, 4'hF);
        wr(4'd1, 32'hAABBCCDD, 4'b0101);
        rd(4'd1, 32'h11BB33DD);
        wr(4'd1, 32'hFFFFFFFF, 4'b0000);
        rd(4'd1, 32'h11BB33DD);

        // Latency and back-to-back throughput
        wr(4'd3, 32'hC0DE0003, 4'hF);
        wr(4'd4, 32'hC0DE0004, 4'hF);
        wr(4'd5, 32'hC0DE0005, 4'hF);
        tick();
        rd(4'd3, 32'hC0DE0003);
        rd(4'd4, 32'hC0DE0004);
        rd(4'd5, 32'hC0DE0005);
        tick();
        tick();
        tick();

        // Collisions: full-word then partial-byte write to the address being read
        wr(4'd9, 32'h00000055, 4'hF);
        op(1'b1, 4'd9, 32'h0000003C, 4'hF, 1'b1, 4'd9, 32'h0000003C, 32'h00000055, 1'b0);
        rd(4'd9, 32'h0000003C);
        op(1'b1, 4'd9, 32'hAABBCCDD, 4'b0011, 1'b1, 4'd9, 32'h0000CCDD, 32'h0000003C, 1'b0);
        rd(4'd9, 32'h0000CCDD);

        // Independent read and write to different addresses
        op(1'b1, 4'd10, 32'h12345678, 4'hF, 1'b1, 4'd3, 32'hC0DE0003, 32'hC0DE0003, 1'b0);
        rd(4'd10, 32'h12345678);

`ifdef RAM_DP_CLR_PARITY_EN
        wr(4'd2, 32'h0000000F, 4'hF);
        tick();
        force u_a.par_mem[2] = 4'b0001;
        force u_b.par_mem[2] = 4'b0001;
        op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd2, 32'h0000000F, 32'h0000000F, 1'b1);
        op(1'b0, 4'd0, 32'd0, 4'd0, 1'b1, 4'd3, 32'hC0DE0003, 32'hC0DE0003, 1'b0);
        tick();
        tick();
        release u_a.par_mem[2];
        release u_b.par_mem[2];
`endif

        repeat (5) tick();
        done = 1'b1;
        repeat (5) tick();
    end

endmodule
